// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: memory arbiter request/grant/read-data
// plus the valid/ready instruction stream towards decode.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single outstanding memory read,
// small instruction queue to decode, redirect flush.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_unit_if.master bus
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = CW + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DATA_W-1:0] q_instr_q [QDEPTH];
  logic [ADDR_W-1:0] q_pc_q    [QDEPTH];

  logic              head_valid;
  logic              pop;
  logic              push;
  logic              push_we;
  logic [OW-1:0]     occ_next;
  logic              req;
  logic              accept;

  // Handshake terms; requests only when the slot for the
  // returning data is already guaranteed.
  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid & bus.instr_ready;
    push       = inflight_q;
    occ_next   = {1'b0, count_q} + OW'(push) - OW'(pop);
    req        = reset & ~redirect_valid
               & (occ_next < OW'(QDEPTH));
    accept     = req & bus.mem_gnt;
    push_we    = reset & push & ~redirect_valid;
  end

  // Next-state for PC, in-flight tracking and queue pointers;
  // a redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = accept;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    count_d       = count_q + CW'(push) - CW'(pop);
    if (accept) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage; contents are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push_we) begin
      q_instr_q[wr_ptr_q] <= bus.mem_rdata;
      q_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // Outputs straight from the head entry, zeroed when empty.
  always_comb begin
    bus.mem_req     = req;
    bus.mem_addr    = fetch_pc_q;
    bus.instr_valid = head_valid;
    bus.instr       = head_valid ? q_instr_q[rd_ptr_q] : '0;
    bus.instr_pc    = head_valid ? q_pc_q[rd_ptr_q] : '0;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the processor decode/execute path. It owns the program counter, issues word reads to the shared single-port memory through a request/grant arbiter, and buffers returned 16-bit instructions with their PCs in a small queue. The queue feeds decode over a valid/ready handshake. It supports a redirect (branch/jump/exception) that flushes the queue and discards any in-flight response.

Parameters:
ADDR_W, 16, word-address and PC width
DATA_W, 16, instruction width
QDEPTH, 2, instruction queue depth; power of 2, at least 2
RESET_PC, 0, PC loaded at reset

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets all state
redirect_valid  in  1  flush the unit and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
mem_req  out  1  fetch read request to the memory arbiter
mem_addr  out  ADDR_W  word address of the request; equals fetch_pc
mem_gnt  in  1  arbiter grant; a request is accepted when mem_req=1 and mem_gnt=1
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after an accepted request
instr_valid  out  1  queue head is valid
instr  out  DATA_W  queue head instruction; 0 when the queue is empty
instr_pc  out  ADDR_W  PC of the queue head; 0 when the queue is empty
instr_ready  in  1  decode accepts the head; pop when instr_valid=1 and instr_ready=1

Behaviour:
- State: fetch_pc; inflight flag plus inflight_pc; circular queue of QDEPTH entries {instr, pc} with rd_ptr, wr_ptr and count (0..QDEPTH).
- Reset (reset=0): fetch_pc=RESET_PC, inflight=0, count=0, both pointers=0. mem_req=0 during the reset cycle. instr_valid=0, instr=0, instr_pc=0.
- Per-cycle terms: pop = instr_valid & instr_ready. push = inflight (mem_rdata is captured this cycle together with inflight_pc). occ_next = count + push - pop.
- mem_req is combinational: mem_req = reset & ~redirect_valid & (occ_next < QDEPTH). This guarantees that every accepted request has a queue slot when its data returns.
- Accepted request: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 mod 2^ADDR_W. So 0xFFFF wraps to 0x0000 with no flag.
- No accepted request: inflight<=0. If mem_gnt=0 while mem_req=1, mem_addr holds and fetch_pc does not advance.
- Throughput is one instruction per cycle with continuous grant and ready. At most one response is in flight. A new request may be accepted in the same cycle a response is pushed.
- Latency: request accepted in cycle N, data pushed at the end of N+1, instr_valid=1 in cycle N+2. After reset release with grant held high, the first instr_valid is 2 cycles after the first request cycle.
- The queue outputs instr, instr_pc and instr_valid=(count!=0) come directly from the head entry, with no extra register stage.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Overflow cannot occur by construction; the bench asserts count<=QDEPTH.
- Redirect (redirect_valid=1): has priority over everything else. That cycle, mem_req=0. At the edge: count<=0, rd_ptr=wr_ptr=0, inflight<=0 (the response arriving this cycle is dropped), fetch_pc<=redirect_pc.
  - A pop in the redirect cycle still counts as accepted by decode; decode is responsible for squashing it.
  - Fetch from redirect_pc starts the next cycle.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: behaves exactly like the reset state. The queue is cleared, and a response returning in the cycle after reset is ignored because inflight=0.

Test Plan:
- Streaming: reset for 2 cycles, then mem_gnt=1, instr_ready=1, mem_rdata=0x8000+addr -> mem_addr 0,1,2,...; instr_pc 0,1,2,... on consecutive cycles starting 2 cycles after the first request; instr=0x8000,0x8001,...
- Backpressure: instr_ready=0 from the first valid -> count reaches 2 (PCs 0,1) and mem_req drops to 0. Release ready -> PCs 0,1,2,3 delivered in order, none lost or duplicated.
- Grant stall: mem_gnt=0 for 3 cycles at fetch_pc=0x0005 -> mem_req=1, mem_addr=0x0005 held for all 3 cycles. After the grant, the next instr_pc is 0x0005.
- Redirect with in-flight: request to 0x0003 accepted, redirect_pc=0x0040 asserted the next cycle -> stale 0x0003 data never appears. Next instr_pc=0x0040, then 0x0041; queue empty in the cycle after the redirect.
- Wrap: redirect to 0xFFFF -> instr_pc sequence 0xFFFF, 0x0000, 0x0001.
- Reset mid-stream with a full queue and a response in flight -> the cycle after reset deasserts, instr_valid=0, instr=0, instr_pc=0, and the next mem_addr=RESET_PC=0x0000.
